// File: rtl/binary_to_gray_encoder_stream_if.sv
// Valid/ready stream bundle for the binary-to-Gray encoder: binary input side and Gray output side.
// Gray_Parity_Out is present only when GRAY_ENCODER_PARITY_EN is defined.
interface binary_to_gray_encoder_stream_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  Binary_Valid_In;
    logic [DATA_WIDTH-1:0] Binary_Data_In;
    logic                  Binary_Ready_Out;
    logic                  Gray_Valid_Out;
    logic                  Gray_Ready_In;
`ifdef GRAY_ENCODER_PARITY_EN
    logic                  Gray_Parity_Out;

    modport slave (
        input  Binary_Valid_In,
        input  Binary_Data_In,
        input  Gray_Ready_In,
        output Binary_Ready_Out,
        output Gray_Valid_Out,
        output Gray_Parity_Out
    );

    modport master (
        output Binary_Valid_In,
        output Binary_Data_In,
        output Gray_Ready_In,
        input  Binary_Ready_Out,
        input  Gray_Valid_Out,
        input  Gray_Parity_Out
    );
`else
    modport slave (
        input  Binary_Valid_In,
        input  Binary_Data_In,
        input  Gray_Ready_In,
        output Binary_Ready_Out,
        output Gray_Valid_Out
    );

    modport master (
        output Binary_Valid_In,
        output Binary_Data_In,
        output Gray_Ready_In,
        input  Binary_Ready_Out,
        input  Gray_Valid_Out
    );
`endif
endinterface

// File: rtl/binary_to_gray_encoder_stream.sv
// Registered binary-to-Gray encoder with a two-entry (main + skid) valid/ready buffer.
// Optional registered parity output enabled by defining GRAY_ENCODER_PARITY_EN.
module binary_to_gray_encoder_stream #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           Clock_In,
    input  logic                           Reset_N_In,
    input  logic                           Enable_In,
    binary_to_gray_encoder_stream_if.slave stream_io,
    // Tristate output kept as a plain port so the high-Z driver sits at a module boundary.
    output logic [DATA_WIDTH-1:0]          Gray_Data_Out
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [DATA_WIDTH-1:0] gray_enc;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  ready_int;
    logic                  valid_int;

    assign gray_enc  = stream_io.Binary_Data_In ^ (stream_io.Binary_Data_In >> 1);

    // Handshake outputs depend only on registered state and the enable.
    assign ready_int = Enable_In & (state_q != StTwo);
    assign valid_int = Enable_In & (state_q != StEmpty);
    assign in_xfer   = stream_io.Binary_Valid_In & ready_int;
    assign out_xfer  = valid_int & stream_io.Gray_Ready_In;

    assign stream_io.Binary_Ready_Out = ready_int;
    assign stream_io.Gray_Valid_Out   = valid_int;
    assign Gray_Data_Out              = Enable_In ? main_q : {DATA_WIDTH{1'bz}};

`ifdef GRAY_ENCODER_PARITY_EN
    logic par_main_q, par_main_d;
    logic par_skid_q, par_skid_d;
    logic par_enc;

    assign par_enc                   = ^gray_enc;
    assign stream_io.Gray_Parity_Out = Enable_In & par_main_q;
`endif

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
`ifdef GRAY_ENCODER_PARITY_EN
        par_main_d = par_main_q;
        par_skid_d = par_skid_q;
`endif
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StOne;
                    main_d  = gray_enc;
`ifdef GRAY_ENCODER_PARITY_EN
                    par_main_d = par_enc;
`endif
                end
            end
            StOne: begin
                if (in_xfer && !out_xfer) begin
                    state_d = StTwo;
                    skid_d  = gray_enc;
`ifdef GRAY_ENCODER_PARITY_EN
                    par_skid_d = par_enc;
`endif
                end else if (!in_xfer && out_xfer) begin
                    state_d = StEmpty;
                end else if (in_xfer && out_xfer) begin
                    main_d = gray_enc;
`ifdef GRAY_ENCODER_PARITY_EN
                    par_main_d = par_enc;
`endif
                end
            end
            StTwo: begin
                if (out_xfer) begin
                    state_d = StOne;
                    main_d  = skid_q;
`ifdef GRAY_ENCODER_PARITY_EN
                    par_main_d = par_skid_q;
`endif
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef GRAY_ENCODER_PARITY_EN
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            par_main_q <= 1'b0;
            par_skid_q <= 1'b0;
        end else begin
            par_main_q <= par_main_d;
            par_skid_q <= par_skid_d;
        end
    end
`endif

endmodule
